myip_v1_0: RTL and testbench

AXI4-Stream coprocessor that evaluates a fixed two-layer fixed-point network over a 64-sample dataset. It receives a 64×7 data matrix A, an 8×2 hidden-layer weight matrix B and a 3×1 output-layer weight vector C as one input packet. It returns one 8-bit result per sample as a 64-word output packet. It sits between the AXI DMA MM2S and S2MM channels as a plain stream slave/master.

---
 rtl/myip_pkg.sv | 25 ++
 rtl/myip_mac_engine.sv | 66 ++++++
 rtl/myip_v1_0.sv | 163 ++++++++++++++++
 tb/tb_myip_v1_0.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/myip_pkg.sv
// Shared constants and FSM state type for the myip_v1_0 stream coprocessor.
package myip_pkg;

  localparam int unsigned A_DEPTH   = 448;
  localparam int unsigned B_DEPTH   = 16;
  localparam int unsigned C_DEPTH   = 3;
  localparam int unsigned RES_DEPTH = 64;
  localparam int unsigned WIDTH     = 8;

  localparam int unsigned A_AW   = 9;
  localparam int unsigned B_AW   = 4;
  localparam int unsigned C_AW   = 2;
  localparam int unsigned RES_AW = 6;

  localparam int unsigned IN_WORDS = A_DEPTH + B_DEPTH + C_DEPTH;
  localparam int unsigned ACC_W    = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_COMPUTE,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/myip_mac_engine.sv
// Two parallel hidden-unit accumulators, hidden activations and the output unit.
// MYIP_SATURATE_EN selects clamping activation; otherwise activation wraps to 8 bits.
module myip_mac_engine
  import myip_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_first,
  input  logic             i_mac,
  input  logic             i_act,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_w0,
  input  logic [WIDTH-1:0] i_w1,
  input  logic [WIDTH-1:0] i_bias0,
  input  logic [WIDTH-1:0] i_bias1,
  input  logic [WIDTH-1:0] i_c0,
  input  logic [WIDTH-1:0] i_c1,
  input  logic [WIDTH-1:0] i_c2,
  output logic [WIDTH-1:0] o_res
);

  logic [ACC_W-1:0] r_acc0, r_acc1;
  logic [WIDTH-1:0] r_h0, r_h1;
  logic [15:0]      w_m0, w_m1, w_p0, w_p1;
  logic [ACC_W-1:0] w_base0, w_base1, w_out;

  // Takes the unshifted sum; the >>8 scaling is part of the activation.
  function automatic logic [WIDTH-1:0] act(input logic [ACC_W-1:0] x);
`ifdef MYIP_SATURATE_EN
    return ((x >> 8) > 19'd255) ? '1 : WIDTH'(x >> 8);
`else
    return WIDTH'(x >> 8);
`endif
  endfunction

  assign w_m0 = {8'b0, i_a} * {8'b0, i_w0};
  assign w_m1 = {8'b0, i_a} * {8'b0, i_w1};

  // First MAC of a row seeds the accumulator with the bias scaled by 256.
  assign w_base0 = i_first ? {3'b0, i_bias0, 8'h00} : r_acc0;
  assign w_base1 = i_first ? {3'b0, i_bias1, 8'h00} : r_acc1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc0 <= '0;
      r_acc1 <= '0;
      r_h0   <= '0;
      r_h1   <= '0;
    end else begin
      if (i_mac) begin
        r_acc0 <= w_base0 + {3'b0, w_m0};
        r_acc1 <= w_base1 + {3'b0, w_m1};
      end
      if (i_act) begin
        r_h0 <= act(r_acc0);
        r_h1 <= act(r_acc1);
      end
    end
  end

  assign w_p0  = {8'b0, i_c1} * {8'b0, r_h0};
  assign w_p1  = {8'b0, i_c2} * {8'b0, r_h1};
  assign w_out = {3'b0, i_c0, 8'h00} + {3'b0, w_p0} + {3'b0, w_p1};
  assign o_res = act(w_out);

endmodule

// File: rtl/myip_v1_0.sv
// AXI4-Stream coprocessor top: input capture into A/B/C RAMs, per-row compute, result stream-out.
// Optional MYIP_SATURATE_EN (in myip_mac_engine) selects saturating activation.
module myip_v1_0
  import myip_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETN,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        M_AXIS_TVALID,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);

  state_t r_state, w_next;

  logic [A_AW-1:0]   r_cnt;
  logic [3:0]        r_phase;
  logic [RES_AW-1:0] r_row;
  logic [A_AW-1:0]   r_a_base;

  logic [WIDTH-1:0] r_a_mem   [A_DEPTH];
  logic [WIDTH-1:0] r_b_mem   [B_DEPTH];
  logic [WIDTH-1:0] r_c_mem   [C_DEPTH];
  logic [WIDTH-1:0] r_res_mem [RES_DEPTH];

  logic [RES_AW:0]  r_rd_addr;
  logic             r_q_vld, r_q_last;
  logic [WIDTH-1:0] r_ram_q;
  logic             r_tvalid, r_tlast;
  logic [WIDTH-1:0] r_tdata;

  logic             w_in_fire, w_out_fire, w_out_free, w_load, w_rd_en, w_row_done;
  logic [A_AW-1:0]  w_a_addr;
  logic [B_AW-1:0]  w_widx;
  logic [WIDTH-1:0] w_res;
  logic             w_unused;

  assign w_unused = ^{S_AXIS_TDATA[31:8], S_AXIS_TLAST};

  assign w_in_fire  = (r_state == ST_READ) && S_AXIS_TVALID;
  assign w_row_done = (r_state == ST_COMPUTE) && (r_phase == 4'd8);
  assign w_out_fire = r_tvalid && M_AXIS_TREADY;
  assign w_out_free = !r_tvalid || M_AXIS_TREADY;
  // Two-stage read pipeline: RAM register feeds the output register; both stall together.
  assign w_load     = (r_state == ST_WRITE) && r_q_vld && w_out_free;
  assign w_rd_en    = (r_state == ST_WRITE) && !r_rd_addr[RES_AW] && (!r_q_vld || w_load);

  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    S_AXIS_TREADY = 1'b0;
    case (r_state)
      ST_IDLE:    if (S_AXIS_TVALID) w_next = ST_READ;
      ST_READ: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && (r_cnt == 9'(IN_WORDS - 1))) w_next = ST_COMPUTE;
      end
      ST_COMPUTE: if (w_row_done && (r_row == 6'(RES_DEPTH - 1))) w_next = ST_WRITE;
      ST_WRITE:   if (w_out_fire && r_tlast) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (w_in_fire) begin
      if (r_cnt < 9'(A_DEPTH))                r_a_mem[r_cnt] <= S_AXIS_TDATA[WIDTH-1:0];
      else if (r_cnt < 9'(A_DEPTH + B_DEPTH)) r_b_mem[r_cnt[B_AW-1:0]] <= S_AXIS_TDATA[WIDTH-1:0];
      else                                    r_c_mem[r_cnt[C_AW-1:0]] <= S_AXIS_TDATA[WIDTH-1:0];
    end
    if (w_row_done) r_res_mem[r_row] <= w_res;
    if (w_rd_en)    r_ram_q <= r_res_mem[r_rd_addr[RES_AW-1:0]];
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_cnt     <= '0;
      r_phase   <= '0;
      r_row     <= '0;
      r_a_base  <= '0;
      r_rd_addr <= '0;
      r_q_vld   <= 1'b0;
      r_q_last  <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= '0;
    end else begin
      case (r_state)
        ST_READ: if (w_in_fire) r_cnt <= r_cnt + 9'd1;
        ST_COMPUTE: begin
          if (r_phase == 4'd8) begin
            r_phase  <= '0;
            r_row    <= r_row + 6'd1;
            r_a_base <= r_a_base + 9'd7;
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        ST_WRITE: begin
          if (w_rd_en) begin
            r_q_vld   <= 1'b1;
            r_q_last  <= (r_rd_addr[RES_AW-1:0] == 6'(RES_DEPTH - 1));
            r_rd_addr <= r_rd_addr + 7'd1;
          end else if (w_load) begin
            r_q_vld <= 1'b0;
          end
          if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= r_ram_q;
            r_tlast  <= r_q_last;
          end else if (w_out_fire) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_phase   <= '0;
          r_row     <= '0;
          r_a_base  <= '0;
          r_rd_addr <= '0;
          r_q_vld   <= 1'b0;
          r_q_last  <= 1'b0;
          r_tvalid  <= 1'b0;
          r_tlast   <= 1'b0;
        end
      endcase
    end
  end

  // Weight row k+1 of B sits at flat index 2k+2 (unit 0) and 2k+3 (unit 1).
  assign w_a_addr = r_a_base + {5'b0, r_phase};
  assign w_widx   = {r_phase[2:0], 1'b0} + 4'd2;

  myip_mac_engine u_mac (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .i_first ((r_state == ST_COMPUTE) && (r_phase == 4'd0)),
    .i_mac   ((r_state == ST_COMPUTE) && (r_phase < 4'd7)),
    .i_act   ((r_state == ST_COMPUTE) && (r_phase == 4'd7)),
    .i_a     (r_a_mem[w_a_addr]),
    .i_w0    (r_b_mem[w_widx]),
    .i_w1    (r_b_mem[w_widx | 4'd1]),
    .i_bias0 (r_b_mem[0]),
    .i_bias1 (r_b_mem[1]),
    .i_c0    (r_c_mem[0]),
    .i_c1    (r_c_mem[1]),
    .i_c2    (r_c_mem[2]),
    .o_res   (w_res)
  );

  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TDATA  = {24'b0, r_tdata};
  assign M_AXIS_TLAST  = r_tlast;

endmodule

// File: tb/tb_myip_v1_0.sv
// Self-checking bench for myip_v1_0: randomized packets against an arithmetic reference model.
`timescale 1ns/1ps
module tb_myip_v1_0;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_tready, s_tlast, s_tvalid;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;

  always #5 aclk = ~aclk;

  myip_v1_0 u_dut (
    .ACLK          (aclk),
    .ARESETN       (aresetn),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TVALID (s_tvalid),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int a_m [64][7];
  int b_m [8][2];
  int c_m [3];
  int exp_r [64];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic int act(input int x);
`ifdef MYIP_SATURATE_EN
    return (x > 255) ? 255 : x;
`else
    return x % 256;
`endif
  endfunction

  function automatic void build_model();
    int s, h0, h1;
    for (int i = 0; i < 64; i++) begin
      s = b_m[0][0] * 256;
      for (int k = 0; k < 7; k++) s += a_m[i][k] * b_m[k+1][0];
      h0 = act(s / 256);
      s = b_m[0][1] * 256;
      for (int k = 0; k < 7; k++) s += a_m[i][k] * b_m[k+1][1];
      h1 = act(s / 256);
      exp_r[i] = act((c_m[0] * 256 + c_m[1] * h0 + c_m[2] * h1) / 256);
    end
  endfunction

  // mode 0: random, 1: all-ones with C={0,128,128}, 2: all 255
  function automatic void fill(input int mode);
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 7; k++)
        a_m[i][k] = (mode == 0) ? int'($urandom_range(0, 255)) : ((mode == 1) ? 1 : 255);
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 2; j++)
        b_m[r][j] = (mode == 0) ? int'($urandom_range(0, 255)) : ((mode == 1) ? 1 : 255);
    for (int j = 0; j < 3; j++)
      c_m[j] = (mode == 0) ? int'($urandom_range(0, 255)) : ((mode == 1) ? ((j == 0) ? 0 : 128) : 255);
    build_model();
  endfunction

  function automatic int word_at(input int idx);
    if (idx < 448) return a_m[idx / 7][idx % 7];
    if (idx < 464) return b_m[(idx - 448) / 2][(idx - 448) % 2];
    return c_m[idx - 464];
  endfunction

  // mode 0: continuous, 1: one-cycle TVALID gap after 2 beats, 2: random gaps
  task automatic send_pkt(input int mode, input int limit);
    int idx = 0;
    int cyc = 0;
    bit dropped = 1'b0;
    bit v, acc;
    while (idx < limit && cyc < 5000) begin
      v = 1'b1;
      if (mode == 1 && idx == 2 && !dropped) begin v = 1'b0; dropped = 1'b1; end
      if (mode == 2 && $urandom_range(0, 3) == 0) v = 1'b0;
      s_tvalid = v;
      s_tdata  = {24'($urandom), 8'(word_at(idx))};
      s_tlast  = 1'($urandom);
      acc = v && s_tready;
      @(posedge aclk); #1;
      if (acc) idx++;
      cyc++;
    end
    s_tvalid = 1'b0;
    check("send_count", idx, limit);
  endtask

  // mode 0: always ready, 1: one-cycle TREADY drop 2 cycles after TVALID rises, 2: random
  task automatic recv_pkt(input int mode, input string tag);
    int n = 0;
    int cyc = 0;
    int vcnt = 0;
    bit r, acc;
    while (n < 64 && cyc < 3000) begin
      r = 1'b1;
      if (mode == 1 && vcnt == 2) r = 1'b0;
      if (mode == 2 && $urandom_range(0, 2) == 0) r = 1'b0;
      m_tready = r;
      if (m_tvalid) begin
        check({tag, "_data"}, int'(m_tdata), exp_r[n]);
        check({tag, "_last"}, int'(m_tlast), (n == 63) ? 1 : 0);
      end
      if (m_tvalid || vcnt > 0) vcnt++;
      acc = m_tvalid && r;
      @(posedge aclk); #1;
      if (acc) n++;
      cyc++;
    end
    check({tag, "_beats"}, n, 64);
    check({tag, "_vld_after"}, int'(m_tvalid), 0);
    m_tready = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tready", int'(s_tready), 0);
    check("rst_tvalid", int'(m_tvalid), 0);
    check("rst_tdata",  int'(m_tdata), 0);
    check("rst_tlast",  int'(m_tlast), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    fill(1);
    send_pkt(0, 467);
    recv_pkt(0, "ones");

    fill(0);
    send_pkt(1, 467);
    recv_pkt(1, "gap");

    fill(2);
    send_pkt(2, 467);
    recv_pkt(2, "max");

    fill(0);
    send_pkt(2, 100);
    aresetn  = 1'b0;
    s_tvalid = 1'b1;
    @(posedge aclk); #1;
    check("midrst_tready", int'(s_tready), 0);
    check("midrst_tvalid", int'(m_tvalid), 0);
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    @(posedge aclk); #1;
    fill(0);
    send_pkt(0, 467);
    recv_pkt(2, "post_rst");

    fill(0);
    send_pkt(2, 467);
    recv_pkt(0, "b2b_first");
    fill(0);
    send_pkt(0, 467);
    recv_pkt(2, "b2b_second");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
